dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state responder for the data-memory load/store port.
// Optional build macro DMEM_MISALIGN_TRAP_EN flags misaligned, reserved and out-of-range accesses.

module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_area,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t state, next_state;
  logic [3:0] wait_cnt;

  logic        lat_write, lat_unsigned;
  logic [1:0]  lat_area;
  logic [31:0] lat_addr, lat_wdata;

  logic        cur_write, cur_unsigned;
  logic [1:0]  cur_area;
  logic [31:0] cur_addr, cur_wdata;

  logic             accept, enter_resp, mem_we, ready_nxt;
  logic [29:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             in_range, access_err;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_lane, old_word, merged_word, load_word, rdata_nxt;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = req_valid && req_ready && (state == ST_IDLE);

  // With zero wait states the response is built on the accepting edge, so the
  // live request is used while idle and the latched copy afterwards.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_write    = req_write;
      cur_area     = req_area;
      cur_unsigned = req_unsigned;
      cur_addr     = req_addr;
      cur_wdata    = req_wdata;
    end else begin
      cur_write    = lat_write;
      cur_area     = lat_area;
      cur_unsigned = lat_unsigned;
      cur_addr     = lat_addr;
      cur_wdata    = lat_wdata;
    end
  end

  always_comb begin
    word_idx = 30'((cur_addr - ADDR_BASE) >> 2);
    in_range = (cur_addr >= ADDR_BASE) && ({2'b00, word_idx} < 32'(DEPTH_WORDS));
    mem_idx  = word_idx[IDX_W-1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    access_err = !in_range
               || ((cur_area == 2'b01) && cur_addr[0])
               || ((cur_area == 2'b10) && (cur_addr[1:0] != 2'b00))
               || (cur_area == 2'b11);
`else
    access_err = 1'b0;
`endif
  end

  // Lane steering: reserved area falls through to word behaviour.
  always_comb begin
    byte_en    = 4'b1111;
    wdata_lane = cur_wdata;
    case (cur_area)
      2'b00: begin
        byte_en    = 4'b0001 << cur_addr[1:0];
        wdata_lane = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{cur_wdata[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        wdata_lane = cur_wdata;
      end
    endcase
  end

  always_comb begin
    old_word = mem[mem_idx];
    for (int b = 0; b < 4; b++) begin
      merged_word[8*b +: 8] = byte_en[b] ? wdata_lane[8*b +: 8] : old_word[8*b +: 8];
    end
  end

  always_comb begin
    case (cur_addr[1:0])
      2'd0:    ld_byte = old_word[7:0];
      2'd1:    ld_byte = old_word[15:8];
      2'd2:    ld_byte = old_word[23:16];
      default: ld_byte = old_word[31:24];
    endcase
    ld_half = cur_addr[1] ? old_word[31:16] : old_word[15:0];
    case (cur_area)
      2'b00:   load_word = cur_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_word = cur_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_word = old_word;
    endcase
    rdata_nxt = (cur_write || !in_range || access_err) ? 32'b0 : load_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd0) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_nxt  = (next_state == ST_IDLE);
    enter_resp = (state != ST_RESP) && (next_state == ST_RESP);
    mem_we     = enter_resp && cur_write && in_range && !access_err && !reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_INIT;
    end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_write    <= 1'b0;
      lat_area     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'b0;
      lat_wdata    <= 32'b0;
    end else if (accept) begin
      lat_write    <= req_write;
      lat_area     <= req_area;
      lat_unsigned <= req_unsigned;
      lat_addr     <= req_addr;
      lat_wdata    <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'b0;
    end else begin
      req_ready  <= ready_nxt;
      resp_valid <= enter_resp;
      if (enter_resp) resp_rdata <= rdata_nxt;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           err_q <= 1'b0;
    else if (enter_resp) err_q <= access_err;
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Storage is deliberately left out of reset; only committed stores touch it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= merged_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus against a byte-level memory model, checked every cycle.
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined for the build.

module tb_dmem_responder;

  localparam int          WS    = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    bit          write;
    logic [1:0]  area;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          accept;
    int          due;
  } req_t;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_area;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS),
    .ADDR_BASE  (BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_area    (req_area),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          cyc, edges_since_rst, tests, fails;
  int          resp_count, last_due, last_resp_cyc, prev_resp_cyc;
  logic [31:0] last_rdata, hold_rdata;
  logic        last_err, hold_err;
  logic [7:0]  mbytes [int];
  req_t        pend [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Byte-addressed view of the memory: resolve lanes, commit stores, extend loads.
  function automatic void model_resp(input req_t r, output logic [31:0] rd, output logic er);
    longint      off;
    int          start, n;
    bit          in_rng;
    logic [31:0] v;
    off    = longint'({32'b0, r.addr}) - longint'({32'b0, BASE});
    in_rng = (off >= 0) && (off < longint'(4 * DEPTH));
    case (r.area)
      2'd0:    begin start = int'(off);      n = 1; end
      2'd1:    begin start = int'(off) & ~1; n = 2; end
      default: begin start = int'(off) & ~3; n = 4; end
    endcase
    er = TRAP && (!in_rng || ((r.area == 2'd1) && r.addr[0])
                || ((r.area == 2'd2) && (r.addr[1:0] != 2'd0)) || (r.area == 2'd3));
    rd = 32'b0;
    if (!in_rng || er) return;
    if (r.write) begin
      for (int i = 0; i < n; i++) mbytes[start + i] = r.wdata[8*i +: 8];
    end else begin
      v = 32'b0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[start + i];
      if (n == 1 && !r.uns && v[7])  v = v | 32'hFFFF_FF00;
      if (n == 2 && !r.uns && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) edges_since_rst = 0;
      else       edges_since_rst++;
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    logic        exp_valid, exp_ready, eer;
    logic [31:0] erd;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend.delete();
        hold_rdata = 32'b0;
        hold_err   = 1'b0;
        checkOutput("rst_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_rdata", resp_rdata, 32'h0);
        checkOutput("rst_err", 32'(resp_err), 32'h0);
      end else begin
        exp_ready = (edges_since_rst >= 1) &&
                    ((pend.size() == 0) ? (cyc > last_due) : (cyc < pend[0].accept));
        exp_valid = (pend.size() > 0) && (pend[0].due == cyc);
        if (exp_valid) begin
          model_resp(pend[0], erd, eer);
          hold_rdata = erd;
          hold_err   = eer;
          last_due   = cyc;
          void'(pend.pop_front());
        end
        if (resp_valid) begin
          resp_count++;
          last_rdata    = resp_rdata;
          last_err      = resp_err;
          prev_resp_cyc = last_resp_cyc;
          last_resp_cyc = cyc;
        end
        checkOutput("valid", 32'(resp_valid), 32'(exp_valid));
        checkOutput("ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("rdata", resp_rdata, hold_rdata);
        checkOutput("err", 32'(resp_err), 32'(hold_err));
      end
    end
  end

  task automatic applyStimulus(input bit w, input logic [1:0] area, input bit uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input bit hold, output int acc);
    req_t r;
    req_write    = w;
    req_area     = area;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    acc          = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc + 1;
        r   = '{write: w, area: area, uns: uns, addr: addr, wdata: wdata, accept: acc, due: acc + WS};
        pend.push_back(r);
        break;
      end
    end
    if (acc < 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: req_ready never rose for addr %h", addr);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pend.size() == 0) break;
    end
    if (pend.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL resp_timeout: %0d responses still pending", pend.size());
      pend.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a1, a2, rc;
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_area = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'b0;
    req_wdata = 32'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 32'(req_ready), 32'h1);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344, 1'b0, a1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("t1_load_word", last_rdata, 32'h1122_3344);
    checkOutput("t1_err", 32'(last_err), 32'h0);

    applyStimulus(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, 1'b0, a1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("t2_byte_merge", last_rdata, 32'h1122_AB44);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_BEEF, 1'b0, a1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("t2_half_merge", last_rdata, 32'hBEEF_AB44);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h8, 32'h0000_8080, 1'b0, a1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("t3_byte_signed", last_rdata, 32'hFFFF_FF80);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h8, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("t3_byte_unsigned", last_rdata, 32'h0000_0080);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("t3_half_signed", last_rdata, 32'hFFFF_8080);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("t3_half_unsigned", last_rdata, 32'h0000_8080);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("t3_byte1_signed", last_rdata, 32'hFFFF_FF80);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, a1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, a2);
    waitIdle();
    checkOutput("t4_accept_gap", 32'(a2 - a1), 32'd4);
    checkOutput("t4_first_latency", 32'(prev_resp_cyc - a1), 32'd2);
    checkOutput("t4_second_latency", 32'(last_resp_cyc - a2), 32'd2);
    checkOutput("t4_second_rdata", last_rdata, 32'h0000_8080);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0102_0304, 1'b0, a1);
    waitIdle();
    rc = resp_count;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, a1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("t5_no_resp", 32'(resp_count - rc), 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("t5_load_prior", last_rdata, 32'h0102_0304);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFE_1234, 1'b0, a1);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("t6_half_0x3", last_rdata, TRAP ? 32'h0 : 32'hFFFF_CAFE);
    checkOutput("t6_half_0x3_err", 32'(last_err), TRAP ? 32'h1 : 32'h0);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h1000, 32'h5555_6666, 1'b0, a1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("oor_load", last_rdata, 32'h0);
    checkOutput("oor_err", 32'(last_err), TRAP ? 32'h1 : 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("oor_no_alias", last_rdata, 32'hCAFE_1234);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'hFFC, 32'h55AA_55AA, 1'b0, a1);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0, 1'b0, a1);
    waitIdle();
    checkOutput("top_byte3", last_rdata, 32'h0000_0055);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
